wb_spm_mul: RTL



---
 rtl/wb_spm_mul_if.sv | 21 ++
 rtl/wb_spm_mul.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_spm_mul_if.sv
// Wishbone slave bus bundle for wb_spm_mul.
interface wb_spm_mul_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_spm_mul.sv
// Wishbone serial-parallel multiplier: 2*WIDTH-bit product, one bit per clock.
// Optional completion interrupt enabled by defining SPM_MUL_IRQ_EN.

// One carry-save slice: holds a sum and carry bit, emits this step's sum bit.
module wb_spm_mul_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pp,
  input  logic sum_in,
  output logic sum_out
);
  logic s_q, c_q, co;

  assign sum_out = s_q ^ c_q ^ pp;
  assign co      = (s_q & c_q) | (s_q & pp) | (c_q & pp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (clr) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (en) begin
      s_q <= sum_in;
      c_q <= co;
    end
  end
endmodule

module wb_spm_mul #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_spm_mul_if.slave wbs,
  output logic        irq
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW);
  localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] x_q, y_q, y_sr;
  logic [PW-1:0]    x_ext, prod_sr;
  logic [PW:0]      sum_chain;
  logic [63:0]      prod_ext;
  logic [CW-1:0]    cnt_q;
  logic             mode_q, signed_q, irq_en_q, done_q, ovr_q, ack_q;
  logic [31:0]      dat_q, p_lo_q, p_hi_q, off, rdata;
  logic             in_win, acc, wr, busy, start, step, ovr_set;
  logic             wr_x, wr_y, wr_ctrl, w1c_done, w1c_ovr;
  logic             unused_off;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = sel[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return m;
  endfunction

  // Bus decode; low address bits are ignored inside a word.
  assign off        = wbs.wbs_adr_i - BASE_ADDR;
  assign unused_off = ^off[1:0];
  assign in_win     = (off[31:5] == 27'd0);
  assign acc        = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & in_win;
  assign wr         = acc & wbs.wbs_we_i;
  assign wr_x       = wr && off[4:2] == 3'd0;
  assign wr_y       = wr && off[4:2] == 3'd1;
  assign wr_ctrl    = wr && off[4:2] == 3'd4;
  assign w1c_done   = wr_ctrl & wbs.wbs_sel_i[1] & wbs.wbs_dat_i[9];
  assign w1c_ovr    = wr_ctrl & wbs.wbs_sel_i[1] & wbs.wbs_dat_i[10];

  assign busy    = (state_q != IDLE);
  assign start   = wr_y & ~busy;
  assign ovr_set = (wr_x | wr_y) & busy;
  assign step    = (state_q == RUN);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In signed mode X is sign-extended across the full 2*WIDTH array, so the
  // truncated carry-save sum is the exact two's-complement product.
  assign x_ext = mode_q ? {{WIDTH{x_q[WIDTH-1]}}, x_q} : {{WIDTH{1'b0}}, x_q};
  assign sum_chain[PW] = 1'b0;

  for (genvar gi = 0; gi < PW; gi++) begin : g_cell
    wb_spm_mul_cell u_cell (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clr     (start),
      .en      (step),
      .pp      (x_ext[gi] & y_sr[0]),
      .sum_in  (sum_chain[gi+1]),
      .sum_out (sum_chain[gi])
    );
  end

  for (genvar gi = 0; gi < 64; gi++) begin : g_ext
    if (gi < PW) begin : g_in
      assign prod_ext[gi] = prod_sr[gi];
    end else begin : g_sx
      assign prod_ext[gi] = mode_q & prod_sr[PW-1];
    end
  end

  // Operand registers and the serial datapath; Y shifts arithmetically in signed mode.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      y_sr    <= '0;
      prod_sr <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      p_lo_q  <= '0;
      p_hi_q  <= '0;
    end else begin
      if (wr_x && !busy) x_q <= WIDTH'(merge(32'(x_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
      if (start) begin
        y_q     <= WIDTH'(merge(32'(y_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
        y_sr    <= WIDTH'(merge(32'(y_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
        mode_q  <= signed_q;
        prod_sr <= '0;
        cnt_q   <= '0;
      end else if (step) begin
        y_sr    <= {mode_q & y_sr[WIDTH-1], y_sr[WIDTH-1:1]};
        prod_sr <= {sum_chain[0], prod_sr[PW-1:1]};
        cnt_q   <= cnt_q + 1'b1;
      end
      if (state_q == FLUSH) begin
        p_lo_q <= prod_ext[31:0];
        p_hi_q <= prod_ext[63:32];
      end
    end
  end

  // Control/status; completion and overrun setting win over a same-cycle w1c.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      signed_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_ctrl && wbs.wbs_sel_i[0]) signed_q <= wbs.wbs_dat_i[0];
      if (state_q == FLUSH) done_q <= 1'b1;
      else if (start || w1c_done) done_q <= 1'b0;
      if (ovr_set) ovr_q <= 1'b1;
      else if (w1c_ovr) ovr_q <= 1'b0;
    end
  end

`ifdef SPM_MUL_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq_en_q <= 1'b0;
    else if (wr_ctrl && wbs.wbs_sel_i[0]) irq_en_q <= wbs.wbs_dat_i[1];
  end
  assign irq = done_q & irq_en_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off[4:2])
      3'd0:    rdata = 32'(x_q);
      3'd1:    rdata = 32'(y_q);
      3'd2:    rdata = p_lo_q;
      3'd3:    rdata = p_hi_q;
      3'd4:    rdata = {21'd0, ovr_q, done_q, busy, 6'd0, irq_en_q, signed_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !wbs.wbs_we_i) ? rdata : 32'd0;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
endmodule
